eth_pcs_tx_gearbox_xn: RTL and testbench

//  Parametrised 66b->W_PMA TX gearbox for the 10GBASE-R PCS, successor of the fixed-width TX gearbox.

---
 rtl/eth_pcs_tx_gearbox_xn.sv | 132 +++++++++++++
 tb/tb_eth_pcs_tx_gearbox_xn.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/eth_pcs_tx_gearbox_xn.sv
`default_nettype none
// ============================================================================
//  Module   : eth_pcs_tx_gearbox_xn
//  Purpose  : 10GBASE-R PCS transmit gearbox, 66-bit blocks -> W_PMA-bit
//             PMA words. It sits between the scrambler and the PMA
//             serialiser, emits one word every cycle with no bubbles, and
//             paces the encoder/scrambler through o_clk_en.
//  Ports    : i_clk        - single clock, one PMA word per cycle
//             i_reset      - synchronous, active-high reset
//             i_sync_hdr   - 2-bit sync header, bit 0 transmitted first
//             i_scr_data   - 64-bit scrambled payload, sent after header
//             i_test_prbs  - PRBS31 test-pattern select (PRBS builds only)
//             o_clk_en     - block request, inputs sampled this cycle
//             o_pma_data   - registered PMA word, bit 0 transmitted first
//             o_trans_cnt  - position in the 33-cycle pacing period
//  Params   : W_PMA        - PMA word width, 16, 32 or 64
//  Options  : ETH_PCS_TX_PRBS31_EN - adds the i_test_prbs port and a PRBS31
//             (x^31 + x^28 + 1) pattern generator that can replace the
//             gearbox output.
//  Revision : 1.0 - initial release
// ============================================================================
module eth_pcs_tx_gearbox_xn #(
    parameter int W_PMA = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [1:0]       i_sync_hdr,
    input  logic [63:0]      i_scr_data,
`ifdef ETH_PCS_TX_PRBS31_EN
    input  logic             i_test_prbs,
`endif
    output logic             o_clk_en,
    output logic [W_PMA-1:0] o_pma_data,
    output logic [5:0]       o_trans_cnt
);

    localparam int W_BLK = 66;
    localparam int P_LEN = 33;
    localparam int W_BUF = W_PMA + W_BLK;

    localparam logic [7:0] c_W_PMA    = 8'(W_PMA);
    localparam logic [7:0] c_FILL_ADV = 8'(W_BLK - W_PMA);
    localparam logic [5:0] c_CNT_LAST = 6'(P_LEN - 1);

    if (W_PMA != 16 && W_PMA != 32 && W_PMA != 64) begin : g_bad_width
        $error("eth_pcs_tx_gearbox_xn: W_PMA must be 16, 32 or 64");
    end

    // ------------------------------------------------------------------
    // Gearbox state. r_buf holds r_fill valid bits LSB-aligned; every bit
    // above r_fill is kept at zero so a new block can simply be OR-ed in.
    // ------------------------------------------------------------------
    logic [7:0]       r_fill;
    logic [W_BUF-1:0] r_buf;
    logic [W_PMA-1:0] r_pma_data;
    logic [5:0]       r_trans_cnt;

    logic             w_req;
    logic [W_BUF-1:0] w_block_ext;
    logic [W_BUF-1:0] w_merged;
    logic [W_PMA-1:0] w_gb_word;
    logic [W_PMA-1:0] w_pma_next;
    logic [7:0]       w_fill_next;

    // Request decision depends only on the fill level, so the upstream
    // encoder never sees a combinational path from its own outputs.
    assign w_req       = (r_fill < c_W_PMA) && !i_reset;
    assign w_block_ext = {{(W_BUF - W_BLK){1'b0}}, i_scr_data, i_sync_hdr};
    assign w_merged    = w_req ? (r_buf | (w_block_ext << r_fill)) : r_buf;
    assign w_gb_word   = w_merged[W_PMA-1:0];
    assign w_fill_next = w_req ? (r_fill + c_FILL_ADV) : (r_fill - c_W_PMA);

`ifdef ETH_PCS_TX_PRBS31_EN
    // ------------------------------------------------------------------
    // PRBS31 generator. Each transmitted bit is the oldest state bit, so an
    // all-ones seed gives 31 leading ones. The LFSR free-runs W_PMA bits per
    // cycle whatever the mode, so switching modes never realigns anything.
    // ------------------------------------------------------------------
    logic [30:0]      r_lfsr;
    logic [30:0]      w_lfsr_next;
    logic [W_PMA-1:0] w_prbs_word;

    function automatic logic [W_PMA+30:0] prbs_advance(input logic [30:0] i_state);
        logic [30:0]      v_state;
        logic [W_PMA-1:0] v_word;
        v_state = i_state;
        v_word  = '0;
        for (int i = 0; i < W_PMA; i++) begin
            v_word[i] = v_state[30];
            v_state   = {v_state[29:0], v_state[30] ^ v_state[27]};
        end
        return {v_state, v_word};
    endfunction

    assign {w_lfsr_next, w_prbs_word} = prbs_advance(r_lfsr);
    assign w_pma_next = i_test_prbs ? w_prbs_word : w_gb_word;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr <= '1;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end
`else
    assign w_pma_next = w_gb_word;
`endif

    // ------------------------------------------------------------------
    // Shift buffer, output register and pacing counter. A reset drops any
    // partially sent block; the next cycle restarts at fill level zero.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fill      <= '0;
            r_buf       <= '0;
            r_pma_data  <= '0;
            r_trans_cnt <= '0;
        end else begin
            r_fill      <= w_fill_next;
            r_buf       <= w_merged >> W_PMA;
            r_pma_data  <= w_pma_next;
            r_trans_cnt <= (r_trans_cnt == c_CNT_LAST) ? 6'd0 : (r_trans_cnt + 6'd1);
        end
    end

    assign o_clk_en    = w_req;
    assign o_pma_data  = r_pma_data;
    assign o_trans_cnt = r_trans_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eth_pcs_tx_gearbox_xn.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_pcs_tx_gearbox_xn
//  Purpose  : Self-checking bench for eth_pcs_tx_gearbox_xn. Instantiates
//             the gearbox at W_PMA = 16, 32 and 64 on shared stimulus and
//             checks hand-computed words, the request cadence, the pacing
//             counter, reset behaviour and the serialised bit stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_eth_pcs_tx_gearbox_xn;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [1:0]  sync = 2'b10;
    logic [63:0] data = '1;
    logic        prbs = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] d32;
    logic [5:0]  cnt32;
    logic        en32;
    logic [63:0] d64;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int W    = 16 << gi;
        localparam int STEP = 64 / W;

        logic         en;
        logic [W-1:0] dout;
        logic [5:0]   cnt;

        bit           q[$];
        int           phase     = 0;
        int           nreq      = 0;
        bit           armed     = 1'b0;
        bit           after_rst = 1'b0;
        logic [30:0]  lfsr      = '1;
        logic [W-1:0] exp_w;
        logic [65:0]  blk;

        eth_pcs_tx_gearbox_xn #(.W_PMA(W)) u_dut (
            .i_clk       (clk),
            .i_reset     (rst),
            .i_sync_hdr  (sync),
            .i_scr_data  (data),
`ifdef ETH_PCS_TX_PRBS31_EN
            .i_test_prbs (prbs),
`endif
            .o_clk_en    (en),
            .o_pma_data  (dout),
            .o_trans_cnt (cnt)
        );

        if (gi == 1) begin : g_tap32
            assign d32   = dout[31:0];
            assign cnt32 = cnt;
            assign en32  = en;
        end
        if (gi == 2) begin : g_tap64
            assign d64 = dout[63:0];
        end

        // Reference: a bit queue holding every block bit accepted but not
        // yet seen on the output. Each cycle the output must be the next W
        // queued bits; the queue must be empty at the start of each period.
        always @(negedge clk) begin
            if (rst) begin
                check_val($sformatf("w%0d_en_in_reset", W), 64'(en), 64'd0);
                q.delete();
                phase     = 0;
                nreq      = 0;
                armed     = 1'b1;
                after_rst = 1'b1;
                lfsr      = '1;
            end else if (armed) begin
                if (after_rst) begin
                    check_val($sformatf("w%0d_data_after_reset", W), 64'(dout), 64'd0);
                    after_rst = 1'b0;
                end else if (q.size() < W) begin
                    check_val($sformatf("w%0d_queue_underflow", W), 64'(q.size()), 64'(W));
                end else begin
                    for (int i = 0; i < W; i++) exp_w[i] = q.pop_front();
                    if (prbs) begin
                        for (int i = 0; i < W; i++) begin
                            exp_w[i] = lfsr[30];
                            lfsr     = {lfsr[29:0], lfsr[30] ^ lfsr[27]};
                        end
                        check_val($sformatf("w%0d_prbs", W), 64'(dout), 64'(exp_w));
                    end else begin
                        check_val($sformatf("w%0d_stream", W), 64'(dout), 64'(exp_w));
                    end
                end
                check_val($sformatf("w%0d_trans_cnt", W), 64'(cnt), 64'(phase));
                check_val($sformatf("w%0d_clk_en", W), 64'(en),
                          64'((phase < 32) && (phase % STEP == 0)));
                if (phase == 0)
                    check_val($sformatf("w%0d_fill_zero", W), 64'(q.size()), 64'd0);
                if (en) begin
                    blk = {data, sync};
                    for (int i = 0; i < 66; i++) q.push_back(blk[i]);
                    nreq++;
                end
                if (phase == 32) begin
                    check_val($sformatf("w%0d_req_per_period", W), 64'(nreq), 64'(W / 2));
                    nreq  = 0;
                    phase = 0;
                end else begin
                    phase++;
                end
            end
        end
    end

    initial begin
        bit found;

        // First block after reset is {all ones, 2'b10}.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;                                  // cycle 0
        @(posedge clk); #1 sync = 2'b01; data = 64'h0;  // cycle 1
        @(negedge clk);
        check_val("c1_w32", 64'(d32), 64'hFFFF_FFFE);
        check_val("c1_w64", d64, 64'hFFFF_FFFF_FFFF_FFFE);
        @(posedge clk); #1 data = 64'h1;                // cycle 2
        @(negedge clk);
        check_val("c2_w32", 64'(d32), 64'hFFFF_FFFF);
        // W=64: header bits 11 left from block 0, then block {0, 01} at bit 2
        check_val("c2_w64", d64, 64'h7);
        @(posedge clk); #1 data = 64'h2;                // cycle 3
        @(negedge clk);
        // W=32: bits 11 left from block 0, then block {1, 01} at bit 2
        check_val("c3_w32", 64'(d32), 64'h17);

        // Incrementing payload with a valid header.
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1 data = data + 64'h1111_2222_3333_4445;
        end

        // Illegal sync headers must pass through untouched.
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            sync = c[0] ? 2'b11 : 2'b00;
            data = ~data + 64'd7;
        end
        sync = 2'b01;

        // One-cycle reset in the middle of a period.
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk); #1;
            if (cnt32 == 6'd17) found = 1'b1;
        end
        check_val("find_cnt17", 64'(found), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst17_data", 64'(d32), 64'd0);
        check_val("rst17_cnt", 64'(cnt32), 64'd0);
        check_val("rst17_en", 64'(en32), 64'd1);
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1 data = data + 64'h0F0F_0000_1234_0001;
        end

`ifdef ETH_PCS_TX_PRBS31_EN
        // PRBS31 from reset: first word is 31 ones then the first feedback 0.
        rst  = 1'b1;
        prbs = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("prbs_first_w32", 64'(d32), 64'h7FFF_FFFF);
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1 data = data + 64'd3;
        end
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
